ext_pipe_fifo: RTL and testbench
================================

// Module: ext_pipe_fifo
// PURPOSE
//  Parametrised immediate/shamt extender with a small output FIFO and valid/ready handshake.
//  Sits between ID and EX in the pipelined CPU. It accepts a raw field plus an extend mode and
//  produces an OUT_W-bit operand, queued with a destination tag.
//  Replaces the fixed 16->32 and 5->32 combinational extenders.
// PARAMETERS
//  IN_W     16  width of raw immediate field
//  OUT_W    32  width of extended result; must satisfy OUT_W >= IN_W
//  SHAMT_W   5  low bits of in_data used by SHAMT mode; must satisfy SHAMT_W <= IN_W
//  DEPTH     2  FIFO entries; power of two, >= 2
//  TAG_W     5  sideband tag carried unchanged with each result
// PORTS
//  clk        in   1        rising-edge clock
//  rst_n      in   1        asynchronous active-low reset
//  flush      in   1        synchronous: discard all queued entries
//  in_valid   in   1        producer has a field this cycle
//  in_ready   out  1        FIFO can accept (registered, = !full)
//  in_data    in   IN_W     raw field
//  in_mode    in   2        00 ZERO, 01 SIGN, 10 LUI, 11 SHAMT
//  in_tag     in   TAG_W    sideband tag
//  out_valid  out  1        head entry valid (= !empty)
//  out_ready  in   1        consumer accepts head
//  out_data   out  OUT_W    extended result at head
//  out_tag    out  TAG_W    tag at head
//  out_count  out  $clog2(DEPTH)+1  current occupancy
// BEHAVIOUR
//  - Push = in_valid & in_ready. Pop = out_valid & out_ready. Both act at the clk edge.
//  - Extension is computed at push time and stored in the FIFO.
//    ZERO : {0, in_data}
//    SIGN : {(OUT_W-IN_W){in_data[IN_W-1]}, in_data}
//    LUI  : in_data << (OUT_W-IN_W), low bits zero
//    SHAMT: {0, in_data[SHAMT_W-1:0]}
//  - Latency: a push in cycle N appears at out_valid/out_data in cycle N+1 if the FIFO was
//    empty. The FIFO is never write-through.
//  - out_data/out_tag come directly from the head register, with no combinational path from
//    in_*. in_ready depends only on occupancy, with no path from out_ready.
//  - Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Occupancy is tracked by a separate
//    counter, 0..DEPTH.
//  - Full (count==DEPTH): in_ready=0. A push attempt is ignored and the producer must hold.
//    A pop while full frees a slot; in_ready rises the next cycle.
//  - Empty (count==0): out_valid=0. out_data/out_tag hold their last head value and must not be
//    relied on.
//  - Simultaneous push and pop when 0<count<DEPTH: count is unchanged and both pointers advance.
//  - flush=1: next cycle count=0, rd_ptr=wr_ptr=0. A push or pop in the same cycle is
//    discarded. flush has priority over everything except rst_n.
//  - Reset (rst_n=0, async, any time including mid-transfer): count=0, pointers=0,
//    out_valid=0, in_ready=1 (once released), out_data=0, out_tag=0, out_count=0.
//    Storage contents are don't-care.
//  - Mode legality: all 4 codes are legal. There is no error output.
// CONFIGURATION
//  EXT_LUI_EN defined  : mode 10 performs LUI as above.
//  EXT_LUI_EN undefined: LUI logic is not built. Mode 10 behaves exactly as ZERO (00).
//  Rest of the interface is identical in both builds.
// TESTING
//  1 Reset: hold rst_n=0 3 cycles -> out_valid=0, in_ready=1, out_count=0, out_data=0.
//  2 Modes (defaults):
//    - 0x8001 SIGN -> 0xFFFF8001
//    - 0x8001 ZERO -> 0x00008001
//    - 0x1234 LUI -> 0x12340000 (0x00001234 without EXT_LUI_EN)
//    - 0xFFE7 SHAMT -> 0x00000007
//    Each result appears one cycle after its push.
//  3 Full/backpressure: out_ready=0, push tags 1,2 -> count=2, in_ready=0.
//    Push of tag 3 is ignored. Raise out_ready -> tags pop 1 then 2, and tag 3 is then accepted.
//  4 Wrap and concurrency: out_ready=1, in_valid=1, 10 back-to-back pushes.
//    - count stays 1 after the first cycle.
//    - Outputs come out in order with tags 0..9.
//    - Pointers wrap 5 times with no loss.
//  5 Flush: count=2, assert flush with in_valid=1 -> next cycle count=0, out_valid=0.
//    The flushed-cycle push is absent. The next push emerges with correct data.
//  6 Async reset mid-op: count=2, drop rst_n between edges -> outputs clear immediately.
//    After release, the first push is returned correctly.

Source files
------------

// File: rtl/ext_pipe_fifo.sv
// ext_pipe_fifo: immediate/shamt extender feeding a small output FIFO with a
// valid/ready handshake on both sides. The extension is computed when an entry
// is pushed, and the extended value is stored in the FIFO.
// Optional feature macro: EXT_LUI_EN. When it is defined, mode 2'b10 performs
// LUI. When it is undefined, mode 2'b10 behaves exactly like ZERO.
module ext_pipe_fifo #(
  parameter int IN_W    = 16,
  parameter int OUT_W   = 32,
  parameter int SHAMT_W = 5,
  parameter int DEPTH   = 2,
  parameter int TAG_W   = 5,
  localparam int PW     = $clog2(DEPTH),
  localparam int CW     = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic [1:0]       in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic [CW-1:0]    out_count
);

  localparam logic [1:0] MODE_ZERO  = 2'b00;
  localparam logic [1:0] MODE_SIGN  = 2'b01;
  localparam logic [1:0] MODE_LUI   = 2'b10;
  localparam logic [1:0] MODE_SHAMT = 2'b11;

  // Extend a raw field to OUT_W bits according to the mode code.
  function automatic logic [OUT_W-1:0] f_extend(input logic [IN_W-1:0] d,
                                                input logic [1:0]      m);
    logic signed [IN_W-1:0] sd;
    logic [OUT_W-1:0]       res;
    sd  = $signed(d);
    res = OUT_W'(d);
    case (m)
      MODE_SIGN:  res = OUT_W'(sd);
`ifdef EXT_LUI_EN
      MODE_LUI:   res = OUT_W'(d) << (OUT_W - IN_W);
`else
      MODE_LUI:   res = OUT_W'(d);
`endif
      MODE_SHAMT: res = OUT_W'(d[SHAMT_W-1:0]);
      default:    res = OUT_W'(d);
    endcase
    return res;
  endfunction

  logic [OUT_W-1:0] r_mem [DEPTH];
  logic [TAG_W-1:0] r_tag [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_in_ready;

  logic             w_out_valid;
  logic             w_push;
  logic             w_pop;
  logic [CW-1:0]    w_count_nxt;

  assign w_out_valid = (r_count != '0);
  assign w_push      = in_valid & r_in_ready;
  assign w_pop       = w_out_valid & out_ready;

  // Occupancy after this edge's push/pop. Flush is handled separately.
  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CW'(1);
      2'b01:   w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Pointers, occupancy and the registered ready. Flush clears everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_in_ready <= 1'b1;
    end else if (flush) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_in_ready <= 1'b1;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count    <= w_count_nxt;
      r_in_ready <= (w_count_nxt != CW'(DEPTH));
    end
  end

  // Storage. It is cleared on reset so the head reads zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
        r_tag[i] <= '0;
      end
    end else if (w_push && !flush) begin
      r_mem[r_wr_ptr] <= f_extend(in_data, in_mode);
      r_tag[r_wr_ptr] <= in_tag;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = w_out_valid;
  assign out_data  = r_mem[r_rd_ptr];
  assign out_tag   = r_tag[r_rd_ptr];
  assign out_count = r_count;

endmodule

// File: tb/tb_ext_pipe_fifo.sv
// Directed testbench for ext_pipe_fifo using the default parameters.
module tb_ext_pipe_fifo;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [1:0]  in_mode;
  logic [4:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_tag;
  logic [1:0]  out_count;

  int n_chk = 0;
  int n_err = 0;

  ext_pipe_fifo dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag),
    .out_count (out_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [15:0] d, input logic [1:0] m,
                        input logic [4:0] t);
    in_valid = v;
    in_data  = d;
    in_mode  = m;
    in_tag   = t;
  endtask

  logic [15:0] mv_data [4];
  logic [1:0]  mv_mode [4];
  logic [31:0] mv_exp  [4];

  initial begin
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
    set_in(1'b0, 16'h0, 2'b00, 5'd0);

    mv_data[0] = 16'h8001; mv_mode[0] = 2'b01; mv_exp[0] = 32'hFFFF8001;
    mv_data[1] = 16'h8001; mv_mode[1] = 2'b00; mv_exp[1] = 32'h00008001;
    mv_data[2] = 16'h1234; mv_mode[2] = 2'b10;
`ifdef EXT_LUI_EN
    mv_exp[2] = 32'h12340000;
`else
    mv_exp[2] = 32'h00001234;
`endif
    mv_data[3] = 16'hFFE7; mv_mode[3] = 2'b11; mv_exp[3] = 32'h00000007;

    // Reset held for three cycles
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_count", 64'(out_count), 64'd0);
    chk("rst_out_data",  64'(out_data),  64'd0);
    chk("rst_out_tag",   64'(out_tag),   64'd0);
    rst_n = 1'b1;
    step();
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    chk("rst_valid_rel", 64'(out_valid), 64'd0);

    // Extension modes, each visible one cycle after its push
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, mv_data[i], mv_mode[i], 5'(i + 20));
      step();
      set_in(1'b0, 16'h0, 2'b00, 5'd0);
      chk("mode_valid", 64'(out_valid), 64'd1);
      chk("mode_data",  64'(out_data),  64'(mv_exp[i]));
      chk("mode_tag",   64'(out_tag),   64'(i + 20));
      step();
      chk("mode_drain", 64'(out_valid), 64'd0);
    end

    // Full and backpressure
    out_ready = 1'b0;
    set_in(1'b1, 16'h0001, 2'b00, 5'd1);
    step();
    set_in(1'b1, 16'h0002, 2'b00, 5'd2);
    step();
    chk("full_count", 64'(out_count), 64'd2);
    chk("full_ready", 64'(in_ready),  64'd0);
    set_in(1'b1, 16'h0003, 2'b00, 5'd3);
    step();
    chk("full_ign_count", 64'(out_count), 64'd2);
    chk("full_head1",     64'(out_tag),   64'd1);
    out_ready = 1'b1;
    step();
    chk("full_pop1_tag",  64'(out_tag),   64'd2);
    chk("full_pop1_cnt",  64'(out_count), 64'd1);
    chk("full_ready_up",  64'(in_ready),  64'd1);
    step();
    chk("full_t3_tag",    64'(out_tag),   64'd3);
    chk("full_t3_data",   64'(out_data),  64'h3);
    chk("full_t3_cnt",    64'(out_count), 64'd1);
    set_in(1'b0, 16'h0, 2'b00, 5'd0);
    step();
    chk("full_empty",     64'(out_valid), 64'd0);

    // Back-to-back pushes with concurrent pops: pointers wrap repeatedly
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      set_in(1'b1, 16'hA000 + 16'(i), 2'b01, 5'(i));
      step();
      chk("wrap_count", 64'(out_count), 64'd1);
      chk("wrap_tag",   64'(out_tag),   64'(i));
      chk("wrap_data",  64'(out_data),  64'(32'hFFFFA000 + 32'(i)));
    end
    set_in(1'b0, 16'h0, 2'b00, 5'd0);
    step();
    chk("wrap_drain", 64'(out_count), 64'd0);

    // Flush with a concurrent push
    out_ready = 1'b0;
    set_in(1'b1, 16'h0004, 2'b00, 5'd4);
    step();
    set_in(1'b1, 16'h0005, 2'b00, 5'd5);
    step();
    chk("fl_pre_count", 64'(out_count), 64'd2);
    flush = 1'b1;
    set_in(1'b1, 16'h0006, 2'b00, 5'd6);
    step();
    flush = 1'b0;
    set_in(1'b0, 16'h0, 2'b00, 5'd0);
    chk("fl_count", 64'(out_count), 64'd0);
    chk("fl_valid", 64'(out_valid), 64'd0);
    chk("fl_ready", 64'(in_ready),  64'd1);
    set_in(1'b1, 16'h7777, 2'b00, 5'd7);
    step();
    set_in(1'b0, 16'h0, 2'b00, 5'd0);
    chk("fl_next_count", 64'(out_count), 64'd1);
    chk("fl_next_tag",   64'(out_tag),   64'd7);
    chk("fl_next_data",  64'(out_data),  64'h7777);
    out_ready = 1'b1;
    step();
    chk("fl_drain", 64'(out_count), 64'd0);

    // Asynchronous reset between clock edges
    out_ready = 1'b0;
    set_in(1'b1, 16'h1111, 2'b01, 5'd10);
    step();
    set_in(1'b1, 16'h2222, 2'b01, 5'd11);
    step();
    set_in(1'b0, 16'h0, 2'b00, 5'd0);
    chk("ar_pre_count", 64'(out_count), 64'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", 64'(out_valid), 64'd0);
    chk("ar_count", 64'(out_count), 64'd0);
    chk("ar_data",  64'(out_data),  64'd0);
    chk("ar_tag",   64'(out_tag),   64'd0);
    #2;
    rst_n = 1'b1;
    step();
    chk("ar_ready", 64'(in_ready), 64'd1);
    set_in(1'b1, 16'h8001, 2'b01, 5'd9);
    step();
    set_in(1'b0, 16'h0, 2'b00, 5'd0);
    chk("ar_push_cnt",  64'(out_count), 64'd1);
    chk("ar_push_tag",  64'(out_tag),   64'd9);
    chk("ar_push_data", 64'(out_data),  64'hFFFF8001);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
